seg_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It cycles a 3-bit digit index, drives the active-low one-hot digit select and the active-low segment pattern for that digit, and inserts a blanking gap between digits to prevent ghosting. Display data is double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new values.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_hex_decode.sv | 16 +
 rtl/seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   - HEX_SEG : 16-entry hex-to-segment table, active-low, bit order g..a
//   - seg_state_e : scan FSM state encoding (show a digit / blank gap)
//   - SEG_OFF, SEL_OFF : all-dark values for the segment and select buses
package seg_pkg;

  typedef enum logic {
    StShow  = 1'b0,
    StBlank = 1'b1
  } seg_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] SEL_OFF = 8'hFF;

  // Index is the nibble value; entry is {g,f,e,d,c,b,a}, 0 = segment lit.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
// Ports:
//   nibble [3:0] : hex value to display
//   dp           : 1 lights the decimal point
//   seg    [7:0] : {dp, g, f, e, d, c, b, a}, 0 = segment lit
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Each digit is lit for CLK_DIV cycles, followed by BLANK_CYC dark cycles. Display
// data is staged on load and committed to the shadow buffer only when the scan
// wraps back to digit 0, so a frame never mixes old and new values.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (blank leading zero digits).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   data [31:0]   : nibble i is the value of digit i
//   dp_mask [7:0] : bit i lights the decimal point of digit i
//   en_mask [7:0] : bit i = 0 keeps digit i dark (sampled live)
//   load          : strobe, captures data/dp_mask into the staging buffer
//   sel [7:0]     : active-low one-hot digit select
//   seg [7:0]     : active-low segments, seg[7] = dp
//   num [2:0]     : current digit index
//   frame_done    : one-cycle pulse when the index wraps to 0
//   pending       : staged data waiting for the next frame boundary
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned DIGITS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  en_mask,
  input  logic        load,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic [2:0]  num,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned CntMax = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] ShowLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [2:0]      NumLast   = 3'(DIGITS - 1);

  seg_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      num_q, num_d;
  logic            first_q, first_d;
  logic            fd_q, fd_d;
  logic            pending_q, pending_d;
  logic [7:0]      sel_q, sel_d;
  logic [7:0]      seg_q, seg_d;
  logic [31:0]     stage_data_q, stage_data_d;
  logic [7:0]      stage_dp_q, stage_dp_d;
  logic [31:0]     shadow_data_q, shadow_data_d;
  logic [7:0]      shadow_dp_q, shadow_dp_d;

  logic            blank_done;
  logic            commit;
  logic [3:0]      cur_nibble;
  logic            cur_dp;
  logic [7:0]      dec_seg;
  logic [7:0]      lz;

  // first_q suppresses the index advance on the very first SHOW after reset,
  // so the scan starts on digit 0 without reporting a frame wrap.
  assign blank_done = (state_q == StBlank) && (cnt_q == BlankLast);
  assign commit     = blank_done && !first_q && (num_q == NumLast);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CntW'(1);
    num_d         = num_q;
    first_d       = first_q;
    fd_d          = 1'b0;
    pending_d     = pending_q;
    stage_data_d  = stage_data_q;
    stage_dp_d    = stage_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;

    // A load on the commit edge bypasses staging and lands directly in shadow.
    if (commit) begin
      fd_d      = 1'b1;
      pending_d = 1'b0;
      if (load) begin
        shadow_data_d = data;
        shadow_dp_d   = dp_mask;
      end else if (pending_q) begin
        shadow_data_d = stage_data_q;
        shadow_dp_d   = stage_dp_q;
      end
    end else if (load) begin
      stage_data_d = data;
      stage_dp_d   = dp_mask;
      pending_d    = 1'b1;
    end

    unique case (state_q)
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d = StBlank;
          cnt_d   = '0;
        end
      end
      StBlank: begin
        if (blank_done) begin
          state_d = StShow;
          cnt_d   = '0;
          if (first_q) begin
            first_d = 1'b0;
          end else if (num_q == NumLast) begin
            num_d = 3'd0;
          end else begin
            num_d = num_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so the first SHOW cycle of a
  // new frame already reflects freshly committed data.
  assign cur_nibble = shadow_data_d[{num_d, 2'b00} +: 4];
  assign cur_dp     = shadow_dp_d[num_d];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Walk from the top digit down; a digit is a leading zero while every digit
  // above it (and itself) is zero with no dp. Digit 0 is always shown.
  always_comb begin
    lz_run = 1'b1;
    lz     = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < int'(DIGITS)) begin
        lz_run = lz_run & (shadow_data_d[4*i +: 4] == 4'h0) & ~shadow_dp_d[i];
        lz[i]  = (i != 0) & lz_run;
      end
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (state_d == StShow) begin
      sel_d = en_mask[num_d] ? ~(8'b1 << num_d) : SEL_OFF;
      seg_d = lz[num_d] ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBlank;
      cnt_q         <= '0;
      num_q         <= 3'd0;
      first_q       <= 1'b1;
      fd_q          <= 1'b0;
      pending_q     <= 1'b0;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
      stage_data_q  <= '0;
      stage_dp_q    <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      num_q         <= num_d;
      first_q       <= first_d;
      fd_q          <= fd_d;
      pending_q     <= pending_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      stage_data_q  <= stage_data_d;
      stage_dp_q    <= stage_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign num        = num_q;
  assign frame_done = fd_q;
  assign pending    = pending_q;

endmodule
